// File: rtl/wptr_handler_lvl.sv
// ============================================================================
// Module   : wptr_handler_lvl
// Function : Write-side pointer manager for an async FIFO with read-pointer
//            synchroniser, registered fill level, almost-full and overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wptr_handler_lvl #(
    parameter int P_ADDR_W   = 4,
    parameter int P_SYNC_STG = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                i_w_en,
    input  logic [P_ADDR_W:0]   i_g_rptr,
    input  logic [P_ADDR_W:0]   i_afull_th,
    input  logic                i_clr_ovf,
    output logic                o_w_acc,
    output logic [P_ADDR_W:0]   o_b_wptr,
    output logic [P_ADDR_W:0]   o_g_wptr,
    output logic [P_ADDR_W:0]   o_level,
    output logic                o_full,
    output logic                o_afull,
    output logic                o_ovf
);

    localparam int               PTR_W = P_ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {P_ADDR_W{1'b0}}};

    // Stage 0 takes the raw asynchronous pointer; only the last stage is used.
    logic [P_SYNC_STG-1:0][PTR_W-1:0] sync_q;
    logic [PTR_W-1:0]                 g_rs;
    logic [PTR_W-1:0]                 r_bin;
    logic [PTR_W-1:0]                 b_nxt;
    logic [PTR_W-1:0]                 g_nxt;
    logic [PTR_W-1:0]                 lvl_nxt;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[P_SYNC_STG-2:0], i_g_rptr};
        end
    end

    assign g_rs = sync_q[P_SYNC_STG-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar i = 0; i < PTR_W; i++) begin : g_g2b
            assign r_bin[i] = ^(g_rs >> i);
        end
    endgenerate

    assign o_w_acc = i_w_en & ~o_full;
    assign b_nxt   = o_b_wptr + {{P_ADDR_W{1'b0}}, o_w_acc};
    assign g_nxt   = b_nxt ^ (b_nxt >> 1);
    assign lvl_nxt = b_nxt - r_bin;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            o_b_wptr <= '0;
            o_g_wptr <= '0;
            o_level  <= '0;
            o_full   <= 1'b0;
            o_afull  <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            o_b_wptr <= b_nxt;
            o_g_wptr <= g_nxt;
            o_level  <= lvl_nxt;
            o_full   <= (lvl_nxt == DEPTH);
            o_afull  <= (lvl_nxt >= i_afull_th);
            // A dropped write takes priority over a clear in the same cycle.
            if (i_w_en && o_full) begin
                o_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                o_ovf <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wptr_handler_lvl.sv
// ============================================================================
// Module   : tb_wptr_handler_lvl
// Function : Scoreboard bench for wptr_handler_lvl against a count-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wptr_handler_lvl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       i_w_en = 1'b0;
    logic [4:0] i_g_rptr = '0;
    logic [4:0] i_afull_th = '0;
    logic       i_clr_ovf = 1'b0;
    logic       o_w_acc;
    logic [4:0] o_b_wptr;
    logic [4:0] o_g_wptr;
    logic [4:0] o_level;
    logic       o_full;
    logic       o_afull;
    logic       o_ovf;

    wptr_handler_lvl #(.P_ADDR_W(4), .P_SYNC_STG(2)) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .i_w_en     (i_w_en),
        .i_g_rptr   (i_g_rptr),
        .i_afull_th (i_afull_th),
        .i_clr_ovf  (i_clr_ovf),
        .o_w_acc    (o_w_acc),
        .o_b_wptr   (o_b_wptr),
        .o_g_wptr   (o_g_wptr),
        .o_level    (o_level),
        .o_full     (o_full),
        .o_afull    (o_afull),
        .o_ovf      (o_ovf)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        bit         chk_acc;
        bit         acc;
        logic [4:0] bptr;
        logic [4:0] gptr;
        logic [4:0] lvl;
        bit         full;
        bit         afull;
        bit         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: plain write/read counts; the read count reaches the
    // writer two edges after it is driven, and is forgotten by a reset.
    int   cyc = 0;
    int   wcount = 0;
    int   rcount = 0;
    int   last_rst = -100;
    int   rhist [0:8191];
    bit   m_full = 1'b0;
    bit   m_ovf = 1'b0;
    bit   m_known = 1'b0;
    bit   auto_rd = 1'b0;
    int   rd_pct = 100;
    int   wq[$];

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst_n_i, input bit w_i, input bit clr_i, input int th_i);
        exp_t e;
        int   seen;
        int   lvl;
        bit   acc;
        @(negedge wclk);
        cyc++;
        // Reader retires a word once it has been stored for three edges.
        if (auto_rd && wq.size() > 0 && wq[0] <= cyc - 3 && $urandom_range(99) < rd_pct) begin
            rcount++;
            void'(wq.pop_front());
        end
        wrst_n     = rst_n_i;
        i_w_en     = w_i;
        i_clr_ovf  = clr_i;
        i_afull_th = 5'(th_i);
        i_g_rptr   = gray5(rcount);
        rhist[cyc] = rcount;
        acc        = w_i && !m_full;
        e.chk_acc  = m_known;
        e.acc      = acc;
        if (!rst_n_i) begin
            wcount   = 0;
            m_full   = 1'b0;
            m_ovf    = 1'b0;
            last_rst = cyc;
            wq.delete();
            e.bptr = '0; e.gptr = '0; e.lvl = '0;
            e.full = 1'b0; e.afull = 1'b0; e.ovf = 1'b0;
        end else begin
            if (acc) begin
                wcount++;
                if (auto_rd) wq.push_back(cyc);
            end
            seen = (cyc - 2 > last_rst) ? rhist[cyc - 2] : 0;
            lvl  = wcount - seen;
            if (w_i && m_full) m_ovf = 1'b1;
            else if (clr_i)    m_ovf = 1'b0;
            m_full  = (lvl == 16);
            e.bptr  = 5'(wcount);
            e.gptr  = gray5(wcount);
            e.lvl   = 5'(lvl);
            e.full  = m_full;
            e.afull = (lvl >= th_i);
            e.ovf   = m_ovf;
        end
        m_known = 1'b1;
        sb.push_back(e);
    endtask

    // Monitor: o_w_acc just before the edge, registered outputs just after.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            #4;
            if (sb.size() > 0 && sb[0].chk_acc) chk("w_acc", 32'(o_w_acc), 32'(sb[0].acc));
            @(posedge wclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("b_wptr", 32'(o_b_wptr), 32'(e.bptr));
                chk("g_wptr", 32'(o_g_wptr), 32'(e.gptr));
                chk("level",  32'(o_level),  32'(e.lvl));
                chk("full",   32'(o_full),   32'(e.full));
                chk("afull",  32'(o_afull),  32'(e.afull));
                chk("ovf",    32'(o_ovf),    32'(e.ovf));
            end
        end
    end

    initial begin
        int th;
        int wait_cyc;

        // Reset held with a write request and a non-zero read pointer (Gray 0x0F).
        rcount = 10;
        repeat (3) step(0, 1, 0, 12);
        rcount = 0;

        // Fill to full with threshold 12, then one dropped write.
        repeat (16) step(1, 1, 0, 12);
        step(1, 1, 0, 12);
        step(1, 0, 0, 12);

        // One word read: full must persist through the synchroniser delay.
        rcount = 1;
        repeat (5) step(1, 0, 0, 12);

        // Overflow clear, refill, clear-with-dropped-write, clear alone.
        step(1, 0, 1, 12);
        step(1, 1, 0, 12);
        step(1, 1, 1, 12);
        step(1, 0, 0, 12);
        step(1, 0, 1, 12);

        // Threshold 0 at an empty FIFO.
        rcount = 0;
        step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);

        // Wrap with a prompt reader.
        auto_rd = 1'b1;
        rd_pct  = 100;
        repeat (40) step(1, 1, 0, 12);
        repeat (10) step(1, 0, 0, 12);

        // Randomised traffic with varying reader speed and one mid-run reset.
        th = 12;
        for (int i = 0; i < 900; i++) begin
            if (i % 60 == 0)  th = $urandom_range(20);
            if (i % 150 == 0) rd_pct = (i % 300 == 0) ? 10 : 70;
            if (i == 450) begin
                rcount = 0;
                step(0, $urandom_range(1), 0, th);
            end else begin
                step(1, ($urandom_range(3) != 0), ($urandom_range(15) == 0), th);
            end
        end
        auto_rd = 1'b0;

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge wclk);
            wait_cyc++;
        end
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
